// File: rtl/fht_input_loader_pkg.sv
// rtl/fht_input_loader_pkg.sv - shared FHT loader parameters and state type
package fht_input_loader_pkg;

    localparam int A_BIT_DEF = 8;
    localparam int D_BIT_DEF = 16;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        KICK      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/fht_input_loader_if.sv
// rtl/fht_input_loader_if.sv - sample stream, control handshake and RAM write bus
interface fht_input_loader_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic             iFHT_RDY;
    logic             oSTART;
    logic [A_BIT-1:0] oADDR_WR;
    logic [D_BIT-1:0] oDATA;
    logic             oWE;
    logic [A_BIT:0]   oFILL;
    logic             oBUSY;

    modport slave (
        input  iDATA, iVALID, iFHT_RDY,
        output oREADY, oSTART, oADDR_WR, oDATA, oWE, oFILL, oBUSY
    );

    modport master (
        output iDATA, iVALID, iFHT_RDY,
        input  oREADY, oSTART, oADDR_WR, oDATA, oWE, oFILL, oBUSY
    );
endinterface

// File: rtl/fht_bit_reverse.sv
// rtl/fht_bit_reverse.sv - combinational index bit reversal
module fht_bit_reverse #(
    parameter int A_BIT = 8
) (
    input  logic [A_BIT-1:0] idx,
    output logic [A_BIT-1:0] rev
);
    for (genvar i = 0; i < A_BIT; i++) begin : g_rev
        assign rev[i] = idx[A_BIT-1-i];
    end
endmodule

// File: rtl/fht_input_loader.sv
// rtl/fht_input_loader.sv - fills FHT RAM with one frame, kicks the transform, waits for done
module fht_input_loader
    import fht_input_loader_pkg::*;
#(
    parameter int A_BIT   = A_BIT_DEF,
    parameter int D_BIT   = D_BIT_DEF,
    parameter int BIT_REV = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fht_input_loader_if.slave bus
);
    loader_state_t    state, state_n;
    logic [A_BIT-1:0] cnt;
    logic [A_BIT-1:0] rev_cnt;
    logic [A_BIT-1:0] wr_addr;
    logic [A_BIT-1:0] addr_q;
    logic [D_BIT-1:0] data_q;
    logic [A_BIT:0]   fill_q;
    logic             ready_q;
    logic             start_q;
    logic             we_q;
    logic             busy_q;
    logic             accept;
    logic             frame_done;

    fht_bit_reverse #(.A_BIT(A_BIT)) u_rev (
        .idx (cnt),
        .rev (rev_cnt)
    );

    assign wr_addr    = (BIT_REV != 0) ? rev_cnt : cnt;
    assign accept     = bus.iVALID & ready_q;
    assign frame_done = (state == WAIT_DONE) & bus.iFHT_RDY;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:      if (accept && (&cnt)) state_n = KICK;
            KICK:      state_n = WAIT_ACK;
            WAIT_ACK:  if (!bus.iFHT_RDY) state_n = WAIT_DONE;
            WAIT_DONE: if (bus.iFHT_RDY) state_n = LOAD;
            default:   state_n = LOAD;
        endcase
    end

    // Ready and start are registered from the next state so that ready stays low
    // through the reset cycle and start lines up with the final RAM write.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            ready_q <= 1'b0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= (state_n == LOAD);
            start_q <= (state_n == KICK);
            we_q    <= accept;
            if (accept) begin
                cnt    <= cnt + 1'b1;
                addr_q <= wr_addr;
                data_q <= bus.iDATA;
                fill_q <= fill_q + 1'b1;
                busy_q <= 1'b1;
            end
            if (frame_done) begin
                cnt    <= '0;
                fill_q <= '0;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.oREADY   = ready_q;
    assign bus.oSTART   = start_q;
    assign bus.oWE      = we_q;
    assign bus.oADDR_WR = addr_q;
    assign bus.oDATA    = data_q;
    assign bus.oFILL    = fill_q;
    assign bus.oBUSY    = busy_q;
endmodule
